// File: rtl/cpu_pkg.sv
// Types shared by the execute and memory stages: the control-unit opcode
// enum and the load/store unit state encoding.
package cpu_pkg;

    typedef enum logic [5:0] {
        CU_ADD  = 6'd0,
        CU_SUB  = 6'd1,
        CU_AND  = 6'd2,
        CU_OR   = 6'd3,
        CU_XOR  = 6'd4,
        CU_SLL  = 6'd5,
        CU_SRL  = 6'd6,
        CU_SRA  = 6'd7,
        CU_SLT  = 6'd8,
        CU_SLTU = 6'd9,
        CU_LB   = 6'd10,
        CU_LH   = 6'd11,
        CU_LW   = 6'd12,
        CU_LBU  = 6'd13,
        CU_LHU  = 6'd14,
        CU_SB   = 6'd15,
        CU_SH   = 6'd16,
        CU_SW   = 6'd17
    } cuOPType;

    localparam cuOPType MEM_OP_FIRST = CU_LB;
    localparam cuOPType MEM_OP_LAST  = CU_SW;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op >= MEM_OP_FIRST) && (op <= MEM_OP_LAST);
    endfunction

    function automatic logic is_store_op(input cuOPType op);
        return (op == CU_SB) || (op == CU_SH) || (op == CU_SW);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the data-memory port: byte enables, store lane
// replication, load extraction with sign/zero extension, alignment check.
module lsu_lane_align
    import cpu_pkg::*;
(
    input  cuOPType     op,
    input  logic [1:0]  addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rdata >> {addr, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        be         = 4'b0000;
        wdata      = store_data;
        load_data  = 32'h0;
        misaligned = 1'b0;

        case (op)
            CU_LB, CU_LBU, CU_SB: be = 4'b0001 << addr;
            CU_LH, CU_LHU, CU_SH: be = addr[1] ? 4'b1100 : 4'b0011;
            CU_LW, CU_SW:         be = 4'b1111;
            default:              be = 4'b0000;
        endcase

        case (op)
            CU_SB:   wdata = {4{store_data[7:0]}};
            CU_SH:   wdata = {2{store_data[15:0]}};
            default: wdata = store_data;
        endcase

        case (op)
            CU_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            CU_LBU:  load_data = {24'h0, byte_sel};
            CU_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            CU_LHU:  load_data = {16'h0, half_sel};
            CU_LW:   load_data = rdata;
            default: load_data = 32'h0;
        endcase

        case (op)
            CU_LH, CU_LHU, CU_SH: misaligned = addr[0];
            CU_LW, CU_SW:         misaligned = (addr != 2'b00);
            default:              misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: runs one req/ack data-memory transaction per load/store and
// stalls upstream until it completes, is rejected as misaligned, or times out.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  aluOP,
    input  logic [31:0] ALUResult,
    input  logic [31:0] storeData,
    output logic        stall,
    output logic        done,
    output logic [31:0] loadData,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] CNT_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    cuOPType     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        err_q, err_d;

    logic        accept;
    cuOPType     al_op;
    logic [1:0]  al_addr;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misal;

    assign accept = (state_q == LSU_IDLE) && start && is_mem_op(aluOP);

    // One aligner serves both ends: in IDLE it formats the incoming request,
    // afterwards it sees the latched op/address to extract the read data.
    assign al_op   = (state_q == LSU_IDLE) ? cuOPType'(aluOP) : op_q;
    assign al_addr = (state_q == LSU_IDLE) ? ALUResult[1:0] : addr_q[1:0];

    lsu_lane_align u_align (
        .op         (al_op),
        .addr       (al_addr),
        .store_data (storeData),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_misal)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        err_d       = err_q;

        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    op_d    = cuOPType'(aluOP);
                    addr_d  = ALUResult;
                    wdata_d = al_wdata;
                    be_d    = al_be;
                    we_d    = is_store_op(cuOPType'(aluOP));
                    cnt_d   = 32'h0;
                    if (al_misal) begin
                        state_d     = LSU_DONE;
                        err_d       = 1'b1;
                        load_data_d = 32'h0;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (mem_ack) begin
                    state_d     = LSU_DONE;
                    err_d       = 1'b0;
                    load_data_d = al_load;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT)) begin
                    state_d     = LSU_DONE;
                    err_d       = 1'b1;
                    load_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LSU_IDLE;
            op_q        <= CU_ADD;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            we_q        <= 1'b0;
            cnt_q       <= 32'h0;
            load_data_q <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    // Port fields are gated so the bus reads as all-zero outside REQ.
    assign mem_req   = (state_q == LSU_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be    = mem_req ? be_q : 4'h0;
    assign mem_wdata = mem_req ? wdata_q : 32'h0;

    assign stall    = accept || (state_q == LSU_REQ);
    assign done     = (state_q == LSU_DONE);
    assign loadData = load_data_q;
    assign err      = err_q;

endmodule
